// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
// Holds the fetch FSM encoding, the default datapath width and the canonical NOP.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetched-instruction buffer: DEPTH entries, circular pointers, flush has priority.
// The caller keeps push away from a full buffer unless a pop happens in the same cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH + 1)-1:0] count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read at a time, results queued for decode.
// A redirect flushes the buffer and marks any in-flight response for discard.
module instr_fetch #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = rv32i_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    input  logic            redirect_i,
    output logic            fetch_stall_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [XLEN-1:0] ir_o,
    output logic [XLEN-1:0] ir_pc_o,
    output logic            ir_valid_o,
    input  logic            ir_ready_i,
    output logic            fetch_err_o
);

    import rv32i_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_state_t      state_q;
    logic              discard_q;
    logic              mem_req_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic              fetch_err_q;

    logic [2*XLEN-1:0] head;
    logic [CntW-1:0]   count;
    logic              full, empty;
    logic              push, pop;
    logic              misaligned, accept;

    assign misaligned    = is_misaligned(pc_i[1:0]);
    assign fetch_stall_o = (state_q != StIdle) || full;
    assign accept        = (state_q == StIdle) && pc_valid_i && !fetch_stall_o && !misaligned;

    // A response that races a redirect is as stale as one already marked for discard.
    assign push = (state_q == StWait) && mem_rvalid_i && !discard_q && !redirect_i;
    assign pop  = ir_valid_o && ir_ready_i;

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(2 * XLEN)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(redirect_i),
        .wdata_i({mem_addr_q, mem_rdata_i}),
        .rdata_o(head),
        .count_o(count),
        .full_o (full),
        .empty_o(empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pc_valid_i && misaligned) begin
                        fetch_err_q <= 1'b1;
                    end else if (accept) begin
                        mem_addr_q <= pc_i;
                        mem_req_q  <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (redirect_i) begin
                        discard_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rvalid_i) begin
                        discard_q <= 1'b0;
                        state_q   <= StIdle;
                    end else if (redirect_i) begin
                        discard_q <= 1'b1;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign fetch_err_o = fetch_err_q;
    assign ir_valid_o  = (count != '0);
    assign ir_o        = empty ? XLEN'(NOP) : head[XLEN-1:0];
    assign ir_pc_o     = empty ? '0 : head[2*XLEN-1:XLEN];

endmodule
